// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types for the read master and the slave FSMs.
// Pure declarations: no logic, no latency, no flow control.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } rd_mst_state_t;

    localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_stall_timer.sv
// Stall watchdog: counts enabled cycles since the last clear and pulses expired once on reaching the limit.
// Pulse is registered (visible the cycle after the limit-th stalled cycle); saturates, no backpressure.
module axil_stall_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = clear ^ count_en ^ CLK ^ RSTn;
            assign expired = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [W-1:0] LIM    = W'(TIMEOUT_CYCLES);
            localparam logic [W-1:0] LIM_M1 = W'(TIMEOUT_CYCLES - 1);

            logic [W-1:0] cnt;

            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    cnt     <= '0;
                    expired <= 1'b0;
                end else if (clear) begin
                    cnt     <= '0;
                    expired <= 1'b0;
                end else begin
                    // Fires only on the step into LIM; once saturated there is no re-pulse.
                    expired <= count_en && (cnt == LIM_M1);
                    if (count_en && (cnt != LIM))
                        cnt <= cnt + W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/axil_rd_master.sv
// AXI4-Lite read initiator, one transaction outstanding; cmd->ARVALID 1 cycle, >=4 cycles per read.
// Stalls on ARREADY/RVALID/rsp_ready indefinitely; timeout only flags a slow slave.
module axil_rd_master
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]            ARPROT,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  timeout
);

    localparam int OFFS = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << OFFS) - 1);

    rd_mst_state_t state, state_nxt;
    logic accept, ar_hs, r_hs, rsp_hs;
    logic stall_clear, stall_en;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ar_hs     = 1'b0;
        r_hs      = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                accept    = 1'b1;
                state_nxt = ADDR;
            end
            ADDR: if (ARREADY) begin
                ar_hs     = 1'b1;
                state_nxt = DATA;
            end
            DATA: if (RVALID) begin
                r_hs      = 1'b1;
                state_nxt = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_hs    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter restarts on entry to each waiting phase.
    assign stall_clear = accept | ar_hs;
    assign stall_en    = ((state == ADDR) && !ARREADY) || ((state == DATA) && !RVALID);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            ARVALID   <= 1'b0;
            ARADDR    <= '0;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= OKAY;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ARADDR    <= cmd_addr & ADDR_MASK;
                ARVALID   <= 1'b1;
                cmd_ready <= 1'b0;
            end
            if (ar_hs) begin
                ARVALID <= 1'b0;
                RREADY  <= 1'b1;
            end
            if (r_hs) begin
                rsp_data  <= RDATA;
                rsp_resp  <= RRESP;
                RREADY    <= 1'b0;
                rsp_valid <= 1'b1;
            end
            if (rsp_hs) begin
                rsp_valid <= 1'b0;
                cmd_ready <= 1'b1;
            end
        end
    end

    assign ARPROT = ARPROT_DEFAULT;

    axil_stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .clear   (stall_clear),
        .count_en(stall_en),
        .expired (timeout)
    );

endmodule

// File: tb/tb_axil_rd_master.sv
// Self-checking bench for axil_rd_master: table vectors, hand-written reset/timeout sequences, random reads.
module tb_axil_rd_master;
    import axil_pkg::*;

    localparam int TO = 8;

    logic        CLK, RSTn;
    logic        cmd_valid, cmd_ready;
    logic [5:0]  cmd_addr;
    logic        ARVALID, ARREADY;
    logic [5:0]  ARADDR;
    logic [2:0]  ARPROT;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    axil_rd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .timeout(timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  addr;
        int          aw, rw, pw;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [5:0]  exp_ar;
        int          exp_to;
    } vec_t;

    vec_t vecs[8];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick(inout int nto);
        @(negedge CLK);
        if (timeout === 1'b1) nto++;
    endtask

    // Runs one read with the given slave/consumer wait counts and checks every phase.
    task automatic do_read(input logic [5:0] addr, input int aw, input int rw, input int pw,
                           input logic [31:0] data, input logic [1:0] resp,
                           input logic [5:0] exp_ar, input int exp_to, input string tag,
                           output int to_idx);
        int nto;
        bit ok_a, ok_d, ok_r;
        nto = 0; to_idx = -1; ok_a = 1; ok_d = 1; ok_r = 1;
        check({tag, " idle_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        tick(nto);
        cmd_valid = 1'b0;
        cmd_addr  = 6'($urandom);
        for (int i = 0; i <= aw; i++) begin
            if (!(ARVALID === 1'b1 && ARADDR === exp_ar && RREADY === 1'b0 &&
                  cmd_ready === 1'b0 && rsp_valid === 1'b0)) ok_a = 0;
            if (timeout === 1'b1 && to_idx < 0) to_idx = i;
            ARREADY = (i == aw);
            RVALID  = 1'($urandom);
            RDATA   = $urandom;
            RRESP   = 2'($urandom);
            tick(nto);
        end
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        for (int i = 0; i <= rw; i++) begin
            if (!(RREADY === 1'b1 && ARVALID === 1'b0 && rsp_valid === 1'b0 &&
                  cmd_ready === 1'b0)) ok_d = 0;
            RVALID = (i == rw);
            RDATA  = (i == rw) ? data : $urandom;
            RRESP  = (i == rw) ? resp : 2'($urandom);
            tick(nto);
        end
        for (int i = 0; i <= pw; i++) begin
            if (!(rsp_valid === 1'b1 && rsp_data === data && rsp_resp === resp &&
                  RREADY === 1'b0 && ARVALID === 1'b0 && cmd_ready === 1'b0)) ok_r = 0;
            RVALID    = 1'($urandom);
            RDATA     = $urandom;
            RRESP     = 2'($urandom);
            rsp_ready = (i == pw);
            tick(nto);
        end
        rsp_ready = 1'b0;
        RVALID    = 1'b0;
        check({tag, " addr_phase"}, ok_a, 1);
        check({tag, " data_phase"}, ok_d, 1);
        check({tag, " resp_phase"}, ok_r, 1);
        check({tag, " cmd_ready_back"}, cmd_ready, 1);
        check({tag, " rsp_valid_low"}, rsp_valid, 0);
        check({tag, " timeout_pulses"}, nto, exp_to);
    endtask

    initial begin
        int dummy, idx;
        logic [5:0]  a;
        logic [31:0] d;
        logic [1:0]  r;
        int aw, rw, pw;

        vecs[0] = '{6'h0C, 0, 0, 0, 32'hDEADBEEF, OKAY,   6'h0C, 0};
        vecs[1] = '{6'h0E, 3, 0, 5, 32'h12345678, OKAY,   6'h0C, 0};
        vecs[2] = '{6'h10, 0, 1, 0, 32'h00000000, SLVERR, 6'h10, 0};
        vecs[3] = '{6'h3F, 1, 2, 1, 32'hCAFEF00D, DECERR, 6'h3C, 0};
        vecs[4] = '{6'h05, 0, 9, 0, 32'hA5A5A5A5, EXOKAY, 6'h04, 1};
        vecs[5] = '{6'h07, 8, 8, 0, 32'h0F0F0F0F, OKAY,   6'h04, 2};
        vecs[6] = '{6'h09, 7, 7, 2, 32'hFFFFFFFF, SLVERR, 6'h08, 0};
        vecs[7] = '{6'h33, 2, 0, 3, 32'h00C0FFEE, OKAY,   6'h30, 0};

        RSTn = 1'b0; cmd_valid = 0; cmd_addr = 0; ARREADY = 0;
        RVALID = 0; RDATA = 0; RRESP = 0; rsp_ready = 0;
        dummy = 0;

        // Reset state
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst ARVALID", ARVALID, 0);
        check("rst ARADDR", ARADDR, 0);
        check("rst RREADY", RREADY, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst rsp_resp", rsp_resp, 0);
        check("rst timeout", timeout, 0);
        check("rst ARPROT", ARPROT, 0);
        RSTn = 1'b1;
        tick(dummy);
        tick(dummy);
        check("idle ARVALID", ARVALID, 0);

        foreach (vecs[k])
            do_read(vecs[k].addr, vecs[k].aw, vecs[k].rw, vecs[k].pw, vecs[k].data,
                    vecs[k].resp, vecs[k].exp_ar, vecs[k].exp_to, $sformatf("vec%0d", k), idx);

        // Long AR stall: single pulse on ADDR cycle index 8, then normal completion
        do_read(6'h21, 20, 0, 0, 32'h55AA55AA, OKAY, 6'h20, 1, "ar_timeout", idx);
        check("ar_timeout pulse_cycle", 64'(idx), 64'(TO));

        // Async reset while in DATA
        cmd_valid = 1'b1; cmd_addr = 6'h18;
        tick(dummy);
        cmd_valid = 1'b0; ARREADY = 1'b1;
        tick(dummy);
        ARREADY = 1'b0;
        tick(dummy);
        check("mid data RREADY", RREADY, 1);
        #2 RSTn = 1'b0;
        #1;
        check("mid rst ARVALID", ARVALID, 0);
        check("mid rst RREADY", RREADY, 0);
        check("mid rst rsp_valid", rsp_valid, 0);
        check("mid rst cmd_ready", cmd_ready, 1);
        tick(dummy);
        tick(dummy);
        RSTn = 1'b1;
        tick(dummy);
        do_read(6'h04, 1, 1, 1, 32'h600DF00D, OKAY, 6'h04, 0, "after_rst", idx);

        // Async reset while in ADDR
        cmd_valid = 1'b1; cmd_addr = 6'h2A;
        tick(dummy);
        cmd_valid = 1'b0;
        check("mid addr ARVALID", ARVALID, 1);
        #2 RSTn = 1'b0;
        #1;
        check("addr rst ARVALID", ARVALID, 0);
        check("addr rst ARADDR", ARADDR, 0);
        tick(dummy);
        RSTn = 1'b1;
        tick(dummy);

        // Random reads against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            a  = 6'($urandom);
            d  = $urandom;
            r  = 2'($urandom);
            aw = $urandom_range(0, 11);
            rw = $urandom_range(0, 11);
            pw = $urandom_range(0, 4);
            do_read(a, aw, rw, pw, d, r, 6'((a / 4) * 4),
                    ((aw >= TO) ? 1 : 0) + ((rw >= TO) ? 1 : 0),
                    $sformatf("rnd%0d", n), idx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
